// File: rtl/slc3_mem_responder_if.sv
// -----------------------------------------------------------------------------
// slc3_mem_responder_if
// Request/response bundle between the SLC-3 datapath (MAR/MDR, control unit)
// and the memory responder, including the board switch/display signals.
//
// Signals:
//   Mem_OE, Mem_WE  read / write request levels from the control unit
//   ADDR            address from MAR
//   Data_In         write data from MDR
//   SW              board switches (already synchronized), readable at IO_ADDR
//   Data_Out        read data toward the MDR mux
//   Rd_Valid        one-cycle strobe, Data_Out holds a newly completed read
//   Hex_Out         hex display register
//   Wr_Fault        one-cycle strobe, a protected write was dropped
//
// Modports: master = CPU/board side, slave = memory responder.
// -----------------------------------------------------------------------------
interface slc3_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              Mem_OE;
    logic              Mem_WE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_In;
    logic [DATA_W-1:0] SW;
    logic [DATA_W-1:0] Data_Out;
    logic              Rd_Valid;
    logic [DATA_W-1:0] Hex_Out;
    logic              Wr_Fault;

    modport master (
        output Mem_OE, Mem_WE, ADDR, Data_In, SW,
        input  Data_Out, Rd_Valid, Hex_Out, Wr_Fault
    );

    modport slave (
        input  Mem_OE, Mem_WE, ADDR, Data_In, SW,
        output Data_Out, Rd_Valid, Hex_Out, Wr_Fault
    );
endinterface

// File: rtl/slc3_mem_responder.sv
// -----------------------------------------------------------------------------
// slc3_mem_responder
// Memory-side responder for the SLC-3 datapath. Services Mem_OE / Mem_WE
// requests against the MAR address and MDR data using an on-chip RAM with a
// two-stage read pipeline (2-edge latency, one read per cycle), and a
// memory-mapped I/O word at IO_ADDR (reads return SW, writes load Hex_Out).
//
// Ports:
//   Clk    system clock, all state on the rising edge
//   Reset  synchronous, active-high; clears outputs and flushes the read
//          pipeline, RAM contents are preserved
//   bus    slc3_mem_responder_if.slave (requests in, read data / display /
//          fault strobe out)
//
// Optional build macro SLC3_WR_PROTECT_EN: RAM writes below PROTECT_TOP are
// dropped and flagged with a one-cycle Wr_Fault pulse. Without the macro every
// in-range address is writable and Wr_Fault stays 0.
// -----------------------------------------------------------------------------
module slc3_mem_responder #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(16'hFFFF),
    parameter logic [ADDR_W-1:0] PROTECT_TOP = ADDR_W'(16'h0040)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    slc3_mem_responder_if.slave    bus
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

`ifdef SLC3_WR_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_req;
    logic              rd_req;
    logic              addr_io;
    logic              addr_ram;
    logic              prot_hit;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;

    logic [DATA_W-1:0] rd_stage_d;
    logic [DATA_W-1:0] rd_stage_q;
    logic              rd_vld1_q;
    logic              rd_vld2_q;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] hex_q;
    logic              wr_fault_d;
    logic              wr_fault_q;

    always_comb begin
        // A write always wins over a simultaneous read request.
        wr_req     = bus.Mem_WE;
        rd_req     = bus.Mem_OE & ~bus.Mem_WE;
        addr_io    = (bus.ADDR == IO_ADDR);
        addr_ram   = (bus.ADDR < DEPTH_A);
        ram_idx    = bus.ADDR[IDX_W-1:0];
        prot_hit   = PROT_EN && (bus.ADDR < PROTECT_TOP);

        // RAM is left untouched while Reset is held.
        ram_we     = wr_req & addr_ram & ~prot_hit & ~Reset;
        wr_fault_d = wr_req & addr_ram & prot_hit;

        // Stage-1 read source; unmapped addresses read as zero.
        rd_stage_d = '0;
        if (addr_io) begin
            rd_stage_d = bus.SW;
        end else if (addr_ram) begin
            rd_stage_d = mem_q[ram_idx];
        end
    end

    // RAM array: no reset so contents survive a CPU reset.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= bus.Data_In;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_stage_q <= '0;
            rd_vld1_q  <= 1'b0;
            rd_vld2_q  <= 1'b0;
            data_out_q <= '0;
            hex_q      <= '0;
            wr_fault_q <= 1'b0;
        end else begin
            rd_vld1_q <= rd_req;
            if (rd_req) begin
                rd_stage_q <= rd_stage_d;
            end
            rd_vld2_q <= rd_vld1_q;
            // Data_Out only moves when a read completes; it holds otherwise.
            if (rd_vld1_q) begin
                data_out_q <= rd_stage_q;
            end
            if (wr_req && addr_io) begin
                hex_q <= bus.Data_In;
            end
            wr_fault_q <= wr_fault_d;
        end
    end

    assign bus.Data_Out = data_out_q;
    assign bus.Rd_Valid = rd_vld2_q;
    assign bus.Hex_Out  = hex_q;
    assign bus.Wr_Fault = wr_fault_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_slc3_mem_responder
// Table-driven bench for slc3_mem_responder with a read scoreboard: expected
// read data is queued when a read is launched and popped when the reference
// pipeline says it completes. Builds with or without SLC3_WR_PROTECT_EN.
// -----------------------------------------------------------------------------
module tb_slc3_mem_responder;

`ifdef SLC3_WR_PROTECT_EN
    localparam bit TB_PROT = 1'b1;
`else
    localparam bit TB_PROT = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    slc3_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    slc3_mem_responder dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        oe;
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] sw;
        logic        exp_rdv;
        logic [15:0] exp_hex;
    } vec_t;

    typedef struct {
        logic        known;
        logic [15:0] data;
    } rd_exp_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model state
    logic [15:0] mdl_mem [int];
    rd_exp_t     sbq [$];
    logic        m_v1, m_v2;
    logic [15:0] m_last;
    logic        m_last_known;
    logic [15:0] m_hex;
    logic        m_fault;

    vec_t tbl [25];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input logic rst, input logic oe, input logic we,
                        input logic [15:0] addr, input logic [15:0] din,
                        input logic [15:0] sw);
        rd_exp_t e;
        Reset       = rst;
        bus.Mem_OE  = oe;
        bus.Mem_WE  = we;
        bus.ADDR    = addr;
        bus.Data_In = din;
        bus.SW      = sw;
        @(posedge Clk);
        if (rst) begin
            m_v1 = 1'b0;
            m_v2 = 1'b0;
            sbq.delete();
            m_last = 16'h0;
            m_last_known = 1'b1;
            m_hex = 16'h0;
            m_fault = 1'b0;
        end else begin
            m_v2 = m_v1;
            m_v1 = 1'b0;
            m_fault = 1'b0;
            if (we) begin
                if (addr == 16'hFFFF) begin
                    m_hex = din;
                end else if (addr < 16'd1024) begin
                    if (TB_PROT && addr < 16'h0040) m_fault = 1'b1;
                    else mdl_mem[int'(addr)] = din;
                end
            end else if (oe) begin
                m_v1 = 1'b1;
                if (addr == 16'hFFFF) begin
                    e.known = 1'b1; e.data = sw;
                end else if (addr < 16'd1024) begin
                    e.known = mdl_mem.exists(int'(addr));
                    e.data  = e.known ? mdl_mem[int'(addr)] : 16'h0;
                end else begin
                    e.known = 1'b1; e.data = 16'h0;
                end
                sbq.push_back(e);
            end
        end
        #1;
        chk("rd_valid", {15'h0, bus.Rd_Valid}, {15'h0, m_v2});
        if (m_v2) begin
            if (sbq.size() == 0) begin
                chk("scoreboard_underflow", 16'h1, 16'h0);
            end else begin
                e = sbq.pop_front();
                if (e.known) chk("rd_data", bus.Data_Out, e.data);
                m_last = e.data;
                m_last_known = e.known;
            end
        end else if (m_last_known) begin
            chk("data_hold", bus.Data_Out, m_last);
        end
        chk("hex_out", bus.Hex_Out, m_hex);
        chk("wr_fault", {15'h0, bus.Wr_Fault}, {15'h0, m_fault});
    endtask

    initial begin
        m_v1 = 1'b0; m_v2 = 1'b0; m_last = 16'h0; m_last_known = 1'b1;
        m_hex = 16'h0; m_fault = 1'b0;

        //             oe    we    addr      din       sw        rdv   hex
        tbl[0]  = '{1'b0, 1'b1, 16'h0050, 16'h1234, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 1'b1, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 16'h03FF, 16'h5555, 16'h0000, 1'b1, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 16'hFFFF, 16'h00A5, 16'hBEEF, 1'b1, 16'h00A5};
        tbl[6]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'hBEEF, 1'b0, 16'h00A5};
        tbl[7]  = '{1'b0, 1'b1, 16'h0050, 16'h1111, 16'h0000, 1'b1, 16'h00A5};
        tbl[8]  = '{1'b0, 1'b1, 16'h0051, 16'h2222, 16'h0000, 1'b0, 16'h00A5};
        tbl[9]  = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 1'b0, 16'h00A5};
        tbl[10] = '{1'b1, 1'b0, 16'h0051, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[11] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[13] = '{1'b1, 1'b1, 16'h0060, 16'h7777, 16'h0000, 1'b0, 16'h00A5};
        tbl[14] = '{1'b1, 1'b0, 16'h0060, 16'h0000, 16'h0000, 1'b0, 16'h00A5};
        tbl[15] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[16] = '{1'b0, 1'b1, 16'h0450, 16'hCCCC, 16'h0000, 1'b1, 16'h00A5};
        tbl[17] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 1'b0, 16'h00A5};
        tbl[18] = '{1'b1, 1'b0, 16'h0051, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[19] = '{1'b0, 1'b1, 16'h0052, 16'h3333, 16'h0000, 1'b1, 16'h00A5};
        tbl[20] = '{1'b1, 1'b0, 16'h0052, 16'h0000, 16'h0000, 1'b0, 16'h00A5};
        tbl[21] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[22] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[23] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h00A5};
        tbl[24] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h00A5};

        // reset state
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

        foreach (tbl[i]) begin
            step(1'b0, tbl[i].oe, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].sw);
            chk("tbl_rdv", {15'h0, bus.Rd_Valid}, {15'h0, tbl[i].exp_rdv});
            chk("tbl_hex", bus.Hex_Out, tbl[i].exp_hex);
        end

        // read in flight when Reset arrives: it must be discarded
        step(1'b0, 1'b1, 1'b0, 16'h0051, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0);
        chk("rst_data_out", bus.Data_Out, 16'h0000);
        chk("rst_hex", bus.Hex_Out, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0);
        chk("rst_no_rdv", {15'h0, bus.Rd_Valid}, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0);
        // RAM survives reset
        step(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0);
        chk("post_rst_read", bus.Data_Out, 16'h1111);

        // protection boundary (behaviour depends on build)
        step(1'b0, 1'b0, 1'b1, 16'h0010, 16'h9999, 16'h0);
        chk("fault_low_write", {15'h0, bus.Wr_Fault}, {15'h0, TB_PROT});
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0);
        chk("fault_one_cycle", {15'h0, bus.Wr_Fault}, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0040, 16'h4444, 16'h0);
        if (TB_PROT) begin
            chk("prot_not_written", {15'h0, bus.Data_Out == 16'h9999}, 16'h0);
        end else begin
            chk("unprot_written", bus.Data_Out, 16'h9999);
        end
        chk("boundary_no_fault", {15'h0, bus.Wr_Fault}, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0, 16'h0);
        chk("boundary_read", bus.Data_Out, 16'h4444);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0);
        chk("oor_read", bus.Data_Out, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
